nf10_axis_frame_queue: RTL and testbench
========================================

# nf10_axis_frame_queue

Parametrised store-and-forward receive frame queue between a 10G MAC client interface and an AXI4-Stream master port, all in the `axi_aclk` domain. Replaces the fixed 64-bit receive queue with a configurable data width, buffer depth and frame-count limit. Adds a selectable bad-frame policy (drop or forward-with-error), whole-frame overflow dropping, post-reset resynchronisation and saturating statistics counters.

## Interface
- `C_DATA_WIDTH`, 64: data width in bits; a multiple of 8 in the range 32–256.
- `C_DEPTH_LOG2`, 9: data buffer holds 2^C_DEPTH_LOG2 words.
- `C_MAX_FRAMES_LOG2`, 4: descriptor FIFO holds 2^C_MAX_FRAMES_LOG2 committed frames.
- `C_DROP_BAD`, 1: 1 = discard bad frames; 0 = forward them with `m_axis_err_tvalid`.
- `C_CNT_WIDTH`, 32: width of each statistics counter.

Ports:
- `axi_aclk`  in  1  sole clock.
- `axi_resetn`  in  1  asynchronous, active-low reset.
- `in_data`  in  C_DATA_WIDTH  MAC receive word.
- `in_strb`  in  C_DATA_WIDTH/8  byte enables; contiguous from the LSB.
- `in_valid`  in  1  word valid. The input has no backpressure.
- `in_good_frame`  in  1  one-cycle end-of-frame marker, good frame.
- `in_bad_frame`  in  1  one-cycle end-of-frame marker, bad frame.
- `m_axis_tdata`  out  C_DATA_WIDTH
- `m_axis_tstrb`  out  C_DATA_WIDTH/8
- `m_axis_tvalid`  out  1
- `m_axis_tready`  in  1
- `m_axis_tlast`  out  1
- `m_axis_err_tvalid`  out  1  high on the tlast beat of a forwarded bad frame.
- `stat_rx_frames`  out  C_CNT_WIDTH  frames committed.
- `stat_drop_overflow`  out  C_CNT_WIDTH  frames dropped for lack of space.
- `stat_drop_bad`  out  C_CNT_WIDTH  bad frames discarded (C_DROP_BAD=1 only).

## Operation
- **Storage.** The buffer stores {data, strb} per word. Write pointers are `wr_spec` (speculative) and `wr_commit`; the read pointer is `rd`.
  - Free space = 2^C_DEPTH_LOG2 − (`wr_spec` − `rd`), with pointers one bit wider than the address.
- **Word write.** On an `in_valid` cycle with free space > 0, write at `wr_spec`, increment `wr_spec` and the frame length counter.
  - If free space = 0, set `ovf` and discard the word.
- **End marker.** An end marker is `in_good_frame | in_bad_frame`. If both are high, the frame is bad. A word in the same cycle as the marker belongs to the ending frame.
- **Frame drop.** At the marker, drop the frame if any of these hold: `ovf` set; descriptor FIFO full; or frame bad and C_DROP_BAD=1.
  - Dropping restores `wr_spec` to `wr_commit`.
  - Increment `stat_drop_overflow` for `ovf` or a full descriptor FIFO; otherwise increment `stat_drop_bad`.
- **Frame commit.** Otherwise push descriptor {length in words, err}, set `wr_commit` = `wr_spec`, increment `stat_rx_frames`.
- **Marker housekeeping.** Every marker clears `ovf` and the length counter. A marker with length 0 is ignored and no counter changes.
- **Read FSM.**
  - IDLE: leave when the descriptor FIFO is non-empty; pop a descriptor and go to SEND.
  - SEND: emit `length` beats. On the final beat assert `tlast`, and `err_tvalid` = err.
  - After the final beat, go to SEND again if another descriptor is present, else to IDLE.
  - `rd` advances only on a tvalid&tready handshake.
- **Resync.** After reset release, set `resync`. While `resync` is set, discard words and markers until the first marker, which clears `resync`. No counters change during resync.
- **Counters** saturate at all-ones.

## Timing
- **Reset values.** All outputs are 0, including all counters. Reset clears pointers, FIFOs, FSM state (to IDLE), `ovf` and the length counter, and sets `resync`.
  - Reset mid-frame or mid-output loses all stored data without producing any partial beat.
- **Latency.** If the marker is sampled at edge N and the output is idle, `m_axis_tvalid` rises after edge N+3.
- **Back-to-back frames.** When the next descriptor is already committed, the first beat of frame k+1 follows the tlast beat of frame k on the next cycle with no gap.
- **Sustained throughput.** One beat per cycle while `m_axis_tready` is 1.
- **Handshake.** Once `tvalid` is asserted, it and tdata/tstrb/tlast/err_tvalid hold stable until tready.
- **Free space** is computed from the registered `rd`, so words freed on cycle N are usable by writes from cycle N+1.
- **Read/write collision.** A simultaneous write and read of the same address cannot occur, because uncommitted words are never read.

## Test plan
- **Single good frame.** C_DATA_WIDTH=64. Send 9 words, last strb 0x0F, with the good marker on the last word, tready=1 -> 9 beats. tstrb is 0xFF ×8 then 0x0F, tlast on beat 9, first tvalid 3 cycles after the marker, stat_rx_frames=1.
- **Bad 4-word frame.**
  - C_DROP_BAD=1 -> no output, stat_drop_bad=1.
  - C_DROP_BAD=0 -> 4 beats with err_tvalid=1 only on beat 4, stat_drop_bad=0.
- **Data overflow.** C_DEPTH_LOG2=4, tready=0. Send a 10-word good frame, then an 8-word good frame -> stat_drop_overflow=1. Raise tready -> exactly 10 beats. A subsequent 8-word frame is then accepted and output.
- **Descriptor overflow.** C_MAX_FRAMES_LOG2=2, tready=0. Send five 1-word frames -> fifth dropped, stat_drop_overflow=1. Raise tready -> 4 beats, each with tlast.
- **Back-to-back frames.** Commit frames of 1, 2, 3 and 64 words, then tready=1 -> 70 contiguous beats with tlast on beats 1, 3, 6, 70. With tready toggled pseudo-randomly, data is identical and stable while stalled.
- **Reset mid-operation.** Assert reset mid-input and mid-output; after release, send 3 words plus a good marker -> nothing output, all counters 0. The next 5-word frame is output normally.

Source files
------------

// File: rtl/nf10_axis_frame_queue.sv
// nf10_axis_frame_queue
// Store-and-forward receive frame queue. It accepts words from a 10G MAC
// client interface, which has no backpressure, and sends whole frames out on
// an AXI4-Stream master. A frame is sent only after its end marker has
// committed it. Dropped frames (overflow, full descriptor FIFO, or bad frames
// when C_DROP_BAD=1) are rolled back and never appear on the output.
//
// Ports
//   axi_aclk, axi_resetn         clock, asynchronous active-low reset
//   in_data/in_strb/in_valid     MAC receive word and byte enables
//   in_good_frame/in_bad_frame   one-cycle end-of-frame markers
//   m_axis_*                     AXI4-Stream master; err_tvalid flags the
//                                tlast beat of a forwarded bad frame
//   stat_*                       saturating statistics counters
module nf10_axis_frame_queue #(
  parameter int C_DATA_WIDTH      = 64,
  parameter int C_DEPTH_LOG2      = 9,
  parameter int C_MAX_FRAMES_LOG2 = 4,
  parameter int C_DROP_BAD        = 1,
  parameter int C_CNT_WIDTH       = 32
) (
  input  logic                      axi_aclk,
  input  logic                      axi_resetn,
  input  logic [C_DATA_WIDTH-1:0]   in_data,
  input  logic [C_DATA_WIDTH/8-1:0] in_strb,
  input  logic                      in_valid,
  input  logic                      in_good_frame,
  input  logic                      in_bad_frame,
  output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      m_axis_err_tvalid,
  output logic [C_CNT_WIDTH-1:0]    stat_rx_frames,
  output logic [C_CNT_WIDTH-1:0]    stat_drop_overflow,
  output logic [C_CNT_WIDTH-1:0]    stat_drop_bad
);
  localparam int SW = C_DATA_WIDTH / 8;
  localparam int WW = C_DATA_WIDTH + SW;
  localparam int AW = C_DEPTH_LOG2;
  localparam int PW = C_DEPTH_LOG2 + 1;
  localparam int FA = C_MAX_FRAMES_LOG2;
  localparam int FW = C_MAX_FRAMES_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH      = {1'b1, {AW{1'b0}}};
  localparam logic [FW-1:0] MAX_FRAMES = {1'b1, {FA{1'b0}}};

  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic [WW-1:0] buf_mem      [2**AW];
  logic [PW-1:0] desc_len_mem [2**FA];
  logic          desc_err_mem [2**FA];

  // Write side
  logic          resync_q, ovf_q;
  logic [PW-1:0] len_q, wr_spec_q, wr_commit_q;
  logic [FW-1:0] dwp_q;
  logic [C_CNT_WIDTH-1:0] rx_cnt_q, ovf_cnt_q, bad_cnt_q;

  // Read side
  state_t        state_q;
  logic [FW-1:0] drp_q, frames_q;
  logic [PW-1:0] rem_q, iss_q, rd_q;
  logic          cur_err_q;
  logic          s1_valid_q, s1_last_q, s1_err_q;
  logic [WW-1:0] s1_word_q;
  logic          out_valid_q, out_last_q, out_err_q;
  logic [WW-1:0] out_word_q;

  logic          marker, buf_full, wr_en, ovf_d, desc_full, desc_empty;
  logic          mark_valid, drop_ovf, drop_bad, commit;
  logic [PW-1:0] len_d, wr_spec_d, head_len;
  logic          head_err;
  logic          out_take, s1_take, issue, last_issue, beat_hs;

  function automatic logic [C_CNT_WIDTH-1:0] sat_inc(input logic [C_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Occupancy is measured against the handshaked read pointer, so words
  // already prefetched into the output pipeline still count as used.
  assign marker     = in_good_frame | in_bad_frame;
  assign buf_full   = (wr_spec_q - rd_q) == DEPTH;
  assign wr_en      = !resync_q && in_valid && !buf_full;
  assign ovf_d      = ovf_q | (!resync_q && in_valid && buf_full);
  assign len_d      = len_q + PW'(wr_en);
  assign wr_spec_d  = wr_spec_q + PW'(wr_en);
  // A frame holds its descriptor slot until its tlast beat is accepted.
  assign desc_full  = frames_q == MAX_FRAMES;
  assign mark_valid = !resync_q && marker && (len_d != '0);
  assign drop_ovf   = mark_valid && (ovf_d || desc_full);
  assign drop_bad   = mark_valid && !drop_ovf && in_bad_frame && (C_DROP_BAD != 0);
  assign commit     = mark_valid && !drop_ovf && !drop_bad;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      resync_q    <= 1'b1;
      ovf_q       <= 1'b0;
      len_q       <= '0;
      wr_spec_q   <= '0;
      wr_commit_q <= '0;
      dwp_q       <= '0;
      rx_cnt_q    <= '0;
      ovf_cnt_q   <= '0;
      bad_cnt_q   <= '0;
    end else if (resync_q) begin
      if (marker) resync_q <= 1'b0;
    end else if (marker) begin
      ovf_q     <= 1'b0;
      len_q     <= '0;
      wr_spec_q <= (drop_ovf || drop_bad) ? wr_commit_q : wr_spec_d;
      if (commit) begin
        wr_commit_q <= wr_spec_d;
        dwp_q       <= dwp_q + 1'b1;
        rx_cnt_q    <= sat_inc(rx_cnt_q);
      end
      if (drop_ovf) ovf_cnt_q <= sat_inc(ovf_cnt_q);
      if (drop_bad) bad_cnt_q <= sat_inc(bad_cnt_q);
    end else begin
      ovf_q     <= ovf_d;
      len_q     <= len_d;
      wr_spec_q <= wr_spec_d;
    end
  end

  // NOTE: the storage arrays have no reset. The pointers alone decide which
  // entries are live, so clearing the RAM would only cost logic.
  always_ff @(posedge axi_aclk) begin
    if (wr_en) buf_mem[wr_spec_q[AW-1:0]] <= {in_strb, in_data};
    if (commit) begin
      desc_len_mem[dwp_q[FA-1:0]] <= len_d;
      desc_err_mem[dwp_q[FA-1:0]] <= in_bad_frame;
    end
    if (issue) s1_word_q <= buf_mem[iss_q[AW-1:0]];
  end

  // Two-stage output: a RAM read register (s1) feeding the AXI output
  // register. A stall propagates back combinationally, so the pipeline
  // sustains one beat per cycle and holds steady while tready is low.
  assign out_take   = !out_valid_q || m_axis_tready;
  assign s1_take    = !s1_valid_q || out_take;
  assign issue      = (state_q == S_SEND) && s1_take;
  assign last_issue = issue && (rem_q == PW'(1));
  assign beat_hs    = out_valid_q && m_axis_tready;
  assign desc_empty = dwp_q == drp_q;
  assign head_len   = desc_len_mem[drp_q[FA-1:0]];
  assign head_err   = desc_err_mem[drp_q[FA-1:0]];

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q     <= S_IDLE;
      drp_q       <= '0;
      frames_q    <= '0;
      rem_q       <= '0;
      iss_q       <= '0;
      rd_q        <= '0;
      cur_err_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      out_word_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!desc_empty) begin
            rem_q     <= head_len;
            cur_err_q <= head_err;
            drp_q     <= drp_q + 1'b1;
            state_q   <= S_SEND;
          end
        end
        S_SEND: begin
          if (issue) begin
            iss_q <= iss_q + 1'b1;
            if (last_issue) begin
              // Chain straight into the next committed frame without a gap.
              if (!desc_empty) begin
                rem_q     <= head_len;
                cur_err_q <= head_err;
                drp_q     <= drp_q + 1'b1;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              rem_q <= rem_q - 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (s1_take) begin
        s1_valid_q <= issue;
        s1_last_q  <= last_issue;
        s1_err_q   <= last_issue && cur_err_q;
      end

      if (out_take) begin
        out_valid_q <= s1_valid_q;
        out_last_q  <= s1_valid_q && s1_last_q;
        out_err_q   <= s1_valid_q && s1_err_q;
        if (s1_valid_q) out_word_q <= s1_word_q;
      end

      if (beat_hs) rd_q <= rd_q + 1'b1;
      frames_q <= frames_q + FW'(commit) - FW'(beat_hs && out_last_q);
    end
  end

  assign m_axis_tdata       = out_word_q[C_DATA_WIDTH-1:0];
  assign m_axis_tstrb       = out_word_q[WW-1:C_DATA_WIDTH];
  assign m_axis_tvalid      = out_valid_q;
  assign m_axis_tlast       = out_last_q;
  assign m_axis_err_tvalid  = out_err_q;
  assign stat_rx_frames     = rx_cnt_q;
  assign stat_drop_overflow = ovf_cnt_q;
  assign stat_drop_bad      = bad_cnt_q;

endmodule

// File: tb/tb_nf10_axis_frame_queue.sv
// Directed testbench for nf10_axis_frame_queue. It runs four DUT instances:
//   u0 defaults (drop bad), u1 forward bad, u2 16-word buffer, u3 4 frames.
module tb_nf10_axis_frame_queue;
  localparam int DW = 64, SW = 8, CW = 32, NU = 4, CAPN = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] din [NU];
  logic [SW-1:0] dstrb [NU];
  logic          dv [NU], dg [NU], db [NU], tr [NU];
  logic [DW-1:0] td [NU];
  logic [SW-1:0] ts [NU];
  logic          tv [NU], tl [NU], te [NU];
  logic [CW-1:0] st_rx [NU], st_ovf [NU], st_bad [NU];

  for (genvar g = 0; g < NU; g++) begin : g_dut
    nf10_axis_frame_queue #(
      .C_DATA_WIDTH      (DW),
      .C_DEPTH_LOG2      (g == 2 ? 4 : 9),
      .C_MAX_FRAMES_LOG2 (g == 3 ? 2 : 4),
      .C_DROP_BAD        (g == 1 ? 0 : 1),
      .C_CNT_WIDTH       (CW)
    ) u_dut (
      .axi_aclk           (clk),
      .axi_resetn         (rst_n),
      .in_data            (din[g]),
      .in_strb            (dstrb[g]),
      .in_valid           (dv[g]),
      .in_good_frame      (dg[g]),
      .in_bad_frame       (db[g]),
      .m_axis_tdata       (td[g]),
      .m_axis_tstrb       (ts[g]),
      .m_axis_tvalid      (tv[g]),
      .m_axis_tready      (tr[g]),
      .m_axis_tlast       (tl[g]),
      .m_axis_err_tvalid  (te[g]),
      .stat_rx_frames     (st_rx[g]),
      .stat_drop_overflow (st_ovf[g]),
      .stat_drop_bad      (st_bad[g])
    );
  end

  // Beat capture and stall-stability monitor
  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          l;
    logic          e;
    int            c;
  } beat_t;

  beat_t cap [NU][CAPN];
  int    ncap [NU];
  int    cyc;
  int    stab_err;
  bit    prev_stall [NU];
  logic [DW+SW+1:0] prev_bus [NU];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int u = 0; u < NU; u++) begin
      if (tv[u] && tr[u] && ncap[u] < CAPN) begin
        cap[u][ncap[u]].d <= td[u];
        cap[u][ncap[u]].s <= ts[u];
        cap[u][ncap[u]].l <= tl[u];
        cap[u][ncap[u]].e <= te[u];
        cap[u][ncap[u]].c <= cyc;
        ncap[u] <= ncap[u] + 1;
      end
      if (rst_n && prev_stall[u] && (!tv[u] || {td[u], ts[u], tl[u], te[u]} != prev_bus[u]))
        stab_err <= stab_err + 1;
      prev_stall[u] <= rst_n && tv[u] && !tr[u];
      prev_bus[u]   <= {td[u], ts[u], tl[u], te[u]};
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] exp_word(input int u, input int base, input int i);
    return {32'(u), 32'(base + i)};
  endfunction

  task automatic send_frame(input int u, input int n, input logic bad, input int base,
                            input logic [SW-1:0] lstrb);
    for (int i = 0; i < n; i++) begin
      din[u]   = exp_word(u, base, i);
      dstrb[u] = (i == n - 1) ? lstrb : 8'hFF;
      dv[u]    = 1'b1;
      dg[u]    = (i == n - 1) && !bad;
      db[u]    = (i == n - 1) && bad;
      tick();
    end
    dv[u] = 1'b0;
    dg[u] = 1'b0;
    db[u] = 1'b0;
  endtask

  task automatic wait_beats(input int u, input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (ncap[u] < target && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(ncap[u]), 64'(target));
  endtask

  task automatic check_frame(input int u, input int start, input int n, input int base,
                             input logic [SW-1:0] lstrb, input logic err, input string tag);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d].data", tag, i), cap[u][start+i].d, exp_word(u, base, i));
      check($sformatf("%s[%0d].strb", tag, i), 64'(cap[u][start+i].s),
            (i == n - 1) ? 64'(lstrb) : 64'hFF);
      check($sformatf("%s[%0d].last", tag, i), 64'(cap[u][start+i].l), 64'(i == n - 1));
      check($sformatf("%s[%0d].err", tag, i), 64'(cap[u][start+i].e), 64'(err && (i == n - 1)));
    end
  endtask

  initial begin
    int b, k;
    int lens [4];
    int offs [4];
    logic [SW-1:0] lstr [4];
    lens = '{1, 2, 3, 64};
    offs = '{0, 1, 3, 6};
    lstr = '{8'h01, 8'h03, 8'h07, 8'hFF};
    for (int u = 0; u < NU; u++) begin
      din[u] = '0; dstrb[u] = '0; dv[u] = 1'b0; dg[u] = 1'b0; db[u] = 1'b0; tr[u] = 1'b0;
    end

    // Reset state
    repeat (3) tick();
    check("rst_tvalid", 64'(tv[0]), 64'd0);
    check("rst_tdata", td[0], 64'd0);
    check("rst_tstrb", 64'(ts[0]), 64'd0);
    check("rst_tlast", 64'(tl[0]), 64'd0);
    check("rst_err", 64'(te[0]), 64'd0);
    check("rst_rx", 64'(st_rx[0]), 64'd0);
    check("rst_ovf", 64'(st_ovf[0]), 64'd0);
    check("rst_bad", 64'(st_bad[0]), 64'd0);
    rst_n = 1'b1;
    tick();
    // A bare marker ends the post-reset resynchronisation on every unit
    for (int u = 0; u < NU; u++) dg[u] = 1'b1;
    tick();
    for (int u = 0; u < NU; u++) dg[u] = 1'b0;
    tick();
    check("resync_rx", 64'(st_rx[0]), 64'd0);

    // Single good frame: 9 words, latency, strobes, tlast
    tr[0] = 1'b1;
    b = ncap[0];
    send_frame(0, 9, 1'b0, 'h100, 8'h0F);
    k = 0;
    while (!tv[0] && k < 20) begin
      tick();
      k++;
    end
    check("t1_latency", 64'(k), 64'd3);
    wait_beats(0, b + 9, 40, "t1_count");
    check_frame(0, b, 9, 'h100, 8'h0F, 1'b0, "t1");
    check("t1_rx", 64'(st_rx[0]), 64'd1);

    // Bad frame, dropped
    b = ncap[0];
    send_frame(0, 4, 1'b1, 'h200, 8'hFF);
    repeat (10) tick();
    check("t2a_no_output", 64'(ncap[0]), 64'(b));
    check("t2a_drop_bad", 64'(st_bad[0]), 64'd1);
    check("t2a_rx", 64'(st_rx[0]), 64'd1);

    // Bad frame, forwarded with error flag
    tr[1] = 1'b1;
    send_frame(1, 4, 1'b1, 'h300, 8'hFF);
    wait_beats(1, 4, 30, "t2b_count");
    check_frame(1, 0, 4, 'h300, 8'hFF, 1'b1, "t2b");
    check("t2b_drop_bad", 64'(st_bad[1]), 64'd0);
    check("t2b_rx", 64'(st_rx[1]), 64'd1);

    // Data overflow on a 16-word buffer
    send_frame(2, 10, 1'b0, 'h400, 8'hFF);
    send_frame(2, 8, 1'b0, 'h500, 8'hFF);
    repeat (2) tick();
    check("t3_drop_ovf", 64'(st_ovf[2]), 64'd1);
    check("t3_rx", 64'(st_rx[2]), 64'd1);
    check("t3_stalled", 64'(ncap[2]), 64'd0);
    tr[2] = 1'b1;
    repeat (30) tick();
    check("t3_count", 64'(ncap[2]), 64'd10);
    check_frame(2, 0, 10, 'h400, 8'hFF, 1'b0, "t3a");
    send_frame(2, 8, 1'b0, 'h600, 8'h3F);
    wait_beats(2, 18, 30, "t3_count2");
    check_frame(2, 10, 8, 'h600, 8'h3F, 1'b0, "t3b");
    check("t3_rx2", 64'(st_rx[2]), 64'd2);

    // Descriptor overflow with four frame slots
    for (int f = 0; f < 5; f++) send_frame(3, 1, 1'b0, 'h700 + f, 8'hFF);
    repeat (2) tick();
    check("t4_drop_ovf", 64'(st_ovf[3]), 64'd1);
    check("t4_rx", 64'(st_rx[3]), 64'd4);
    tr[3] = 1'b1;
    repeat (20) tick();
    check("t4_count", 64'(ncap[3]), 64'd4);
    for (int f = 0; f < 4; f++) check_frame(3, f, 1, 'h700 + f, 8'hFF, 1'b0, "t4");

    // Back-to-back frames, tready held high
    tr[0] = 1'b0;
    b = ncap[0];
    for (int f = 0; f < 4; f++) send_frame(0, lens[f], 1'b0, 'h1000 * (f + 1), lstr[f]);
    repeat (3) tick();
    tr[0] = 1'b1;
    wait_beats(0, b + 70, 120, "t5_count");
    check("t5_contiguous", 64'(cap[0][b+69].c - cap[0][b].c), 64'd69);
    for (int f = 0; f < 4; f++)
      check_frame(0, b + offs[f], lens[f], 'h1000 * (f + 1), lstr[f], 1'b0, "t5");
    check("t5_rx", 64'(st_rx[0]), 64'd5);

    // Same frames with pseudo-random tready
    tr[0] = 1'b0;
    b = ncap[0];
    for (int f = 0; f < 4; f++) send_frame(0, lens[f], 1'b0, 'h5000 + 'h1000 * f, lstr[f]);
    k = 0;
    while (ncap[0] < b + 70 && k < 1000) begin
      tr[0] = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    tr[0] = 1'b1;
    check("t5r_count", 64'(ncap[0]), 64'(b + 70));
    for (int f = 0; f < 4; f++)
      check_frame(0, b + offs[f], lens[f], 'h5000 + 'h1000 * f, lstr[f], 1'b0, "t5r");
    check("t5r_stable", 64'(stab_err), 64'd0);
    check("t5r_rx", 64'(st_rx[0]), 64'd9);

    // Reset mid-output and mid-input
    tr[0] = 1'b0;
    send_frame(0, 5, 1'b0, 'h8000, 8'hFF);
    repeat (6) tick();
    check("t6_stalled_valid", 64'(tv[0]), 64'd1);
    din[0] = 64'hDEAD; dstrb[0] = 8'hFF; dv[0] = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_tvalid", 64'(tv[0]), 64'd0);
    check("t6_rst_rx", 64'(st_rx[0]), 64'd0);
    tick();
    dv[0] = 1'b0;
    rst_n = 1'b1;
    tick();
    tr[0] = 1'b1;
    b = ncap[0];
    send_frame(0, 3, 1'b0, 'h9000, 8'hFF);
    repeat (10) tick();
    check("t6_resync_no_output", 64'(ncap[0]), 64'(b));
    check("t6_resync_rx", 64'(st_rx[0]), 64'd0);
    check("t6_resync_ovf", 64'(st_ovf[0]), 64'd0);
    check("t6_resync_bad", 64'(st_bad[0]), 64'd0);
    send_frame(0, 5, 1'b0, 'hA000, 8'h1F);
    wait_beats(0, b + 5, 30, "t6_count");
    check_frame(0, b, 5, 'hA000, 8'h1F, 1'b0, "t6");
    check("t6_rx", 64'(st_rx[0]), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
